fir_tdm_scheduler: RTL and testbench
====================================

// Module: fir_tdm_scheduler
// PURPOSE
//  Time-multiplexed controller for the 5-tap shift-add FIR. NCH sample sources share one serial
//  shift-add accumulator. Round-robin arbitration grants one request at a time. The block keeps a
//  per-channel 4-deep sample history, sequences the 5 tap additions, and returns a tagged result.
//  It replaces NCH parallel filter instances in the multi-channel front end.
// PARAMETERS
//  NCH   4    number of requesting channels (>=2)
//  DW    8    sample width
//  OW    10   result width
//  CHW   2    channel index width, = clog2(NCH)
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst        in   1       synchronous reset, active-low
//  req        in   NCH     per-channel level request; din slice must be stable while req high
//  din        in   NCH*DW  packed samples; channel c at [c*DW +: DW]
//  hist_clr   in   1       one-cycle pulse; clears all channel histories
//  grant      out  NCH     one-hot, one-cycle accept pulse; din[c] captured this cycle
//  busy       out  1       high in every state except IDLE
//  dout_valid out  1       one-cycle result strobe
//  dout_ch    out  CHW     channel of dout, valid with dout_valid
//  dout       out  OW      filter result; holds until the next dout_valid
// BEHAVIOUR
//  - Reset: rst==0 at a rising edge forces IDLE. grant=0, busy=0, dout_valid=0, dout_ch=0, dout=0,
//    all histories=0, acc=0, pending clear=0, RR pointer=NCH-1 (so ch0 wins first).
//  - Reset in mid-operation aborts the operation. The aborted sample produces no result and no
//    history update.
//  - FSM states: IDLE -> ACCUM -> DONE -> IDLE.
//    IDLE: if any req is high, grant the winner at cycle T (grant pulse). Capture din[w] into cur,
//      set acc=0, ch=w, pointer=w, and go to ACCUM with k=0. If no req is high, stay in IDLE.
//    ACCUM: runs 5 cycles (T+1..T+5), one tap per cycle: acc += zext(tap_k >> SH[k]).
//      Taps: tap0=cur, tap1..tap4=hist[ch][0..3] (newest first).
//      SH = {5,4,3,2,1}. Logical shift, truncating.
//      After k=4, go to DONE.
//    DONE (T+6): dout=acc, dout_ch=ch, dout_valid=1. Update hist[ch] = {cur, hist[ch][0..2]};
//      other channels are untouched. Go to IDLE.
//  - Latency and throughput: grant at T, dout_valid at T+6. The next grant comes at T+7 at the
//    earliest, so throughput is one sample per 7 cycles. grant is never high while busy.
//  - Arbitration: the search starts at pointer+1 and wraps modulo NCH; the first high req wins.
//    A request held continuously is served again only after every other active request.
//  - Width: the maximum sum is 7+15+31+63+127 = 243 < 2^OW, so there is no overflow.
//    The accumulator is OW bits. If OW is narrower than 8, results wrap modulo 2^OW.
//  - hist_clr: in IDLE it clears all histories the same cycle and takes priority over a
//    same-cycle capture (the captured sample still uses the cleared history).
//    Outside IDLE it sets a pending flag. The clear is applied on entry to IDLE, after the DONE
//    history write, so the in-flight result is unaffected.
//  - A req dropped without a grant is legal; no state is changed. A req on an out-of-range
//    channel is impossible by construction.
// STRUCTURE
//  - Shared package fir_pkg: DW/OW defaults, NTAP=5, the SH[0:4] shift table,
//    typedef state_t {IDLE, ACCUM, DONE}, the tap-counter width.
//  - Sub-module fir_rr_arbiter (req, pointer -> one-hot winner, valid), purely combinational.
//    The pointer register lives in the parent.
//  - Histories: an NCH x 4 x DW register array. The tap mux is indexed by ch and k.
// TESTING
//  1. Impulse, ch0 only: samples 255,0,0,0,0,0
//     -> dout 7,15,31,63,127,0, each with dout_ch=0.
//  2. Step, ch1 only: 160 x5
//     -> dout 5,15,35,75,155; further samples stay at 155.
//  3. All req held high
//     -> grants ch0,1,2,3,0 with each grant edge 7 cycles apart.
//     Interleaved impulses on ch0 and ch2 give independent 7,15,31... sequences.
//  4. Timing: grant at T -> busy high T+1..T+6, dout_valid only at T+6, no grant before T+7.
//  5. rst low for 1 cycle during ACCUM k=2
//     -> next cycle all outputs 0, no dout_valid. A subsequent ch0 sample of 255 yields 7.
//  6. Prime ch3 with 255; pulse hist_clr during ACCUM of ch3's next sample (0)
//     -> that result is 15; the next ch3 sample 0 yields 0 (histories cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the time-multiplexed 5-tap shift-add FIR controller:
//   default widths, tap count, per-tap shift table, FSM state type and the
//   tap-counter / history-index widths.
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int DW_DEF = 8;           // default sample width
  localparam int OW_DEF = 10;          // default result width
  localparam int NTAP   = 5;           // taps: current sample + 4 history entries
  localparam int HDEPTH = NTAP - 1;    // per-channel history depth
  localparam int KW     = $clog2(NTAP);
  localparam int HW     = $clog2(HDEPTH);

  // Right-shift applied to each tap, indexed by tap number (tap0 = newest).
  localparam logic [2:0] SH_TABLE [NTAP] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/fir_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fir_rr_arbiter
//   Combinational round-robin picker. The search starts at pointer+1 and wraps
//   modulo NCH; the first asserted request wins.
//   Ports:
//     req        in  NCH  request vector
//     pointer    in  CHW  index of the most recently served channel
//     winner     out NCH  one-hot winner (all zero when nothing requests)
//     winner_idx out CHW  binary index of the winner
//     valid      out 1    at least one request is asserted
// ---------------------------------------------------------------------------
module fir_rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] pointer,
  output logic [NCH-1:0] winner,
  output logic [CHW-1:0] winner_idx,
  output logic           valid
);

  function automatic int wrap_idx(input int p, input int i);
    return (p + i) % NCH;
  endfunction

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    // i runs 1..NCH so the last-served channel is considered last.
    for (int i = 1; i <= NCH; i++) begin
      if (!valid && req[wrap_idx(int'(pointer), i)]) begin
        winner[wrap_idx(int'(pointer), i)] = 1'b1;
        winner_idx = CHW'(wrap_idx(int'(pointer), i));
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// ---------------------------------------------------------------------------
// fir_tdm_scheduler
//   Shares one serial shift-add accumulator among NCH sample sources. A
//   round-robin winner is granted in IDLE, its five taps are summed over five
//   ACCUM cycles, and the tagged result is presented in DONE, where that
//   channel's 4-deep history is also shifted.
//   Ports:
//     clk        in  1       rising-edge clock
//     rst        in  1       synchronous reset, active low
//     req        in  NCH     per-channel level request
//     din        in  NCH*DW  packed samples, channel c at [c*DW +: DW]
//     hist_clr   in  1       clear all histories (deferred while busy)
//     grant      out NCH     one-hot accept pulse, din captured this cycle
//     busy       out 1       high outside IDLE
//     dout_valid out 1       one-cycle result strobe
//     dout_ch    out CHW     channel of dout
//     dout       out OW      filter result, held until the next strobe
// ---------------------------------------------------------------------------
module fir_tdm_scheduler
  import fir_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = DW_DEF,
  parameter int OW  = OW_DEF,
  parameter int CHW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] din,
  input  logic              hist_clr,
  output logic [NCH-1:0]    grant,
  output logic              busy,
  output logic              dout_valid,
  output logic [CHW-1:0]    dout_ch,
  output logic [OW-1:0]     dout
);

  logic [DW-1:0] din_arr [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_din
      assign din_arr[gi] = din[gi*DW +: DW];
    end
  endgenerate

  state_t         state_reg, state_next;
  logic [CHW-1:0] ptr_reg;
  logic [CHW-1:0] ch_reg;
  logic [KW-1:0]  k_reg;
  logic [DW-1:0]  cur_reg;
  logic [OW-1:0]  acc_reg;
  logic           pend_reg;
  logic [DW-1:0]  hist_reg [NCH][HDEPTH];
  logic [OW-1:0]  dout_reg;
  logic [CHW-1:0] dout_ch_reg;
  logic           dout_valid_reg;

  logic [NCH-1:0] arb_winner;
  logic [CHW-1:0] arb_idx;
  logic           arb_valid;

  logic           capture;
  logic           last_tap;
  logic           clr_now;
  logic [HW-1:0]  hidx;
  logic [DW-1:0]  tap;
  logic [OW-1:0]  term;
  logic [OW-1:0]  acc_sum;

  fir_rr_arbiter #(
    .NCH(NCH),
    .CHW(CHW)
  ) u_arb (
    .req       (req),
    .pointer   (ptr_reg),
    .winner    (arb_winner),
    .winner_idx(arb_idx),
    .valid     (arb_valid)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = '0;
    capture    = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          grant      = arb_winner;
          capture    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (last_tap) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- tap datapath ----------------
  // Taps 1..4 map to history slots 0..3; subtracting one from k in HW bits
  // gives that slot directly.
  assign hidx     = HW'(k_reg - KW'(1));
  assign tap      = (k_reg == '0) ? cur_reg : hist_reg[ch_reg][hidx];
  assign term     = OW'(tap >> SH_TABLE[k_reg]);
  assign acc_sum  = acc_reg + term;
  assign last_tap = (k_reg == KW'(NTAP - 1));

  // A clear requested while busy is held until the DONE history write has
  // happened, so the sample in flight still sees the old history.
  assign clr_now = ((state_reg == IDLE) && hist_clr) ||
                   ((state_reg == DONE) && (pend_reg || hist_clr));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg        <= CHW'(NCH - 1);
      ch_reg         <= '0;
      k_reg          <= '0;
      cur_reg        <= '0;
      acc_reg        <= '0;
      pend_reg       <= 1'b0;
      dout_reg       <= '0;
      dout_ch_reg    <= '0;
      dout_valid_reg <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < HDEPTH; j++) begin
          hist_reg[c][j] <= '0;
        end
      end
    end else begin
      dout_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (capture) begin
            cur_reg <= din_arr[arb_idx];
            ch_reg  <= arb_idx;
            ptr_reg <= arb_idx;
            acc_reg <= '0;
            k_reg   <= '0;
          end
        end
        ACCUM: begin
          acc_reg <= acc_sum;
          if (last_tap) begin
            // Result registered here so it is on the outputs during DONE.
            k_reg          <= '0;
            dout_reg       <= acc_sum;
            dout_ch_reg    <= ch_reg;
            dout_valid_reg <= 1'b1;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          for (int j = HDEPTH - 1; j > 0; j--) begin
            hist_reg[ch_reg][j] <= hist_reg[ch_reg][j-1];
          end
          hist_reg[ch_reg][0] <= cur_reg;
        end
        default: begin
        end
      endcase

      if (state_reg == DONE) begin
        pend_reg <= 1'b0;
      end else if (hist_clr && (state_reg == ACCUM)) begin
        pend_reg <= 1'b1;
      end

      // Placed after the DONE write so a clear overrides the shift.
      if (clr_now) begin
        for (int c = 0; c < NCH; c++) begin
          for (int j = 0; j < HDEPTH; j++) begin
            hist_reg[c][j] <= '0;
          end
        end
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_ch    = dout_ch_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_scheduler
//   Directed stimulus for fir_tdm_scheduler with a cycle-level behavioural
//   model (arithmetic filter sum per grant, per-channel history arrays) that
//   is compared against the DUT on every falling edge, plus literal expected
//   results for each directed transaction.
// ---------------------------------------------------------------------------
module tb_fir_tdm_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int OW  = 10;
  localparam int CHW = 2;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] din;
  logic              hist_clr;
  logic [NCH-1:0]    grant;
  logic              busy;
  logic              dout_valid;
  logic [CHW-1:0]    dout_ch;
  logic [OW-1:0]     dout;

  fir_tdm_scheduler #(
    .NCH(NCH),
    .DW (DW),
    .OW (OW),
    .CHW(CHW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .hist_clr  (hist_clr),
    .grant     (grant),
    .busy      (busy),
    .dout_valid(dout_valid),
    .dout_ch   (dout_ch),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = idle, 1..6 = cycles since the grant (result shown at 6).
  int m_phase, m_ptr, m_cur, m_ch, m_res, m_dout, m_dch;
  bit m_pend;
  bit m_ready = 1'b0;
  int m_hist [NCH][4];
  int c_w, c_ed, c_ec;

  function automatic int filt(input int s, input int h0, input int h1,
                              input int h2, input int h3);
    return ((s >> 5) + (h0 >> 4) + (h1 >> 3) + (h2 >> 2) + (h3 >> 1)) % (1 << OW);
  endfunction

  function automatic void model_clear_hist();
    for (int c = 0; c < NCH; c++)
      for (int j = 0; j < 4; j++)
        m_hist[c][j] = 0;
  endfunction

  always @(negedge clk) begin
    c_w = -1;
    if (m_phase == 0) begin
      for (int i = 1; i <= NCH; i++) begin
        if (c_w < 0 && req[(m_ptr + i) % NCH]) c_w = (m_ptr + i) % NCH;
      end
    end
    if (m_ready) begin
      c_ed = (m_phase == 6) ? m_res : m_dout;
      c_ec = (m_phase == 6) ? m_ch  : m_dch;
      chk("model_grant", int'(grant), (c_w >= 0) ? (1 << c_w) : 0);
      chk("model_busy", int'(busy), int'(m_phase != 0));
      chk("model_dout_valid", int'(dout_valid), int'(m_phase == 6));
      chk("model_dout", int'(dout), c_ed);
      chk("model_dout_ch", int'(dout_ch), c_ec);
    end
    // advance the model to what the next rising edge should produce
    if (!rst) begin
      m_ready = 1'b1;
      m_phase = 0;
      m_ptr   = NCH - 1;
      m_pend  = 1'b0;
      m_dout  = 0;
      m_dch   = 0;
      model_clear_hist();
    end else if (m_ready) begin
      if (m_phase == 0) begin
        if (hist_clr) model_clear_hist();
        if (c_w >= 0) begin
          m_cur   = int'(din[c_w*DW +: DW]);
          m_ch    = c_w;
          m_ptr   = c_w;
          m_res   = filt(m_cur, m_hist[c_w][0], m_hist[c_w][1],
                         m_hist[c_w][2], m_hist[c_w][3]);
          m_phase = 1;
        end
      end else if (m_phase < 6) begin
        if (hist_clr) m_pend = 1'b1;
        m_phase++;
      end else begin
        m_dout = m_res;
        m_dch  = m_ch;
        for (int j = 3; j > 0; j--) m_hist[m_ch][j] = m_hist[m_ch][j-1];
        m_hist[m_ch][0] = m_cur;
        if (m_pend || hist_clr) model_clear_hist();
        m_pend  = 1'b0;
        m_phase = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // clr_mode: 0 none, 1 hist_clr together with the request (IDLE),
  //           2 hist_clr one cycle, two cycles after the grant (ACCUM)
  task automatic send(input int ch, input int sample, input int clr_mode,
                      input int exp, input string name);
    int n;
    @(posedge clk); #1;
    din[ch*DW +: DW] = DW'(sample);
    req[ch] = 1'b1;
    if (clr_mode == 1) hist_clr = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!grant[ch] && n < 50);
    if (!grant[ch]) begin
      timeout({name, "_grant"});
      req[ch]  = 1'b0;
      hist_clr = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req[ch]  = 1'b0;
    hist_clr = 1'b0;
    if (clr_mode == 2) begin
      @(posedge clk); #1;
      hist_clr = 1'b1;
      @(posedge clk); #1;
      hist_clr = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dout_valid && n < 20);
    if (!dout_valid) begin
      timeout({name, "_valid"});
      return;
    end
    chk(name, int'(dout), exp);
    chk({name, "_ch"}, int'(dout_ch), ch);
    $display("txn %s: ch=%0d sample=%0d dout=%0d dout_ch=%0d", name, ch, sample, dout, dout_ch);
  endtask

  // ---------------- directed sequence ----------------
  int imp_exp [6]  = '{7, 15, 31, 63, 127, 0};
  int imp_smp [6]  = '{255, 0, 0, 0, 0, 0};
  int step_exp [6] = '{5, 15, 35, 75, 155, 155};
  int rr_exp [8]   = '{7, 0, 7, 0, 15, 0, 15, 0};

  initial begin
    int n, g, gc, prev;
    rst      = 1'b0;
    req      = '0;
    din      = '0;
    hist_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_grant", int'(grant), 0);

    // 1. impulse on ch0
    for (int i = 0; i < 6; i++) send(0, imp_smp[i], 0, imp_exp[i], "t1_impulse");

    // 2. step on ch1
    for (int i = 0; i < 6; i++) send(1, 160, 0, step_exp[i], "t2_step");

    // 5. reset during ACCUM k=2 aborts the sample
    @(posedge clk); #1;
    din[0 +: DW] = 8'd255;
    req[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!grant[0] && n < 50);
    if (!grant[0]) timeout("t5_grant");
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_dout", int'(dout), 0);
    chk("t5_dout_ch", int'(dout_ch), 0);
    chk("t5_grant", int'(grant), 0);
    repeat (10) begin
      @(negedge clk);
      chk("t5_no_valid", int'(dout_valid), 0);
    end
    send(0, 255, 0, 7, "t5_after");

    // 3. all requests held: round robin from ch0, 7 cycles per grant
    do_reset(1);
    @(posedge clk); #1;
    din = '0;
    din[0*DW +: DW] = 8'd255;
    din[2*DW +: DW] = 8'd255;
    req = '1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (grant == '0 && n < 50);
      if (grant == '0) begin
        timeout("t3_grant");
        break;
      end
      gc = cyc;
      g = -1;
      for (int c = 0; c < NCH; c++) if (grant[c]) g = c;
      chk("t3_order", g, i % NCH);
      if (i > 0) chk("t3_spacing", gc - prev, 7);
      prev = gc;
      @(posedge clk); #1;
      din[g*DW +: DW] = '0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!dout_valid && n < 20);
      if (!dout_valid) begin
        timeout("t3_valid");
        break;
      end
      chk("t3_dout", int'(dout), rr_exp[i]);
      chk("t3_dout_ch", int'(dout_ch), g);
      $display("txn t3_rr: grant ch=%0d cycle=%0d dout=%0d", g, gc, dout);
    end
    @(posedge clk); #1;
    req = '0;

    // 6. hist_clr during ACCUM is deferred; in IDLE it applies at once
    send(3, 255, 0, 7,  "t6_prime");
    send(3, 0,   2, 15, "t6_clr_accum");
    send(3, 0,   0, 0,  "t6_cleared");
    send(3, 255, 0, 7,  "t6_prime2");
    send(3, 0,   1, 0,  "t6_clr_idle");

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
